// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared types for the 16-bit pipeline (ALU opcodes, memc fields,
//           execute-stage FSM states).
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef logic [15:0] uword16;
    typedef logic [31:0] uword32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOT   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_PASSB = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_DIV   = 4'd11
    } alu_op_t;

    localparam int unsigned MEMC_MEMWR = 0;
    localparam int unsigned MEMC_MEM2R = 1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

`default_nettype wire

// File: rtl/stage_two_md_unit.sv
// ============================================================================
// md_unit : iterative unsigned multiply (shift-add) / divide (restoring),
//           one bit per cycle, result {remainder, quotient} for divide.
// Revision: 1.0
// ============================================================================
`default_nettype none

module md_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MD_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  alu_op_t            op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(MD_CYCLES);

    logic                 busy_q,   busy_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     opnd_q,   opnd_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;

    logic                 w_last;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_next;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_last = (cnt_q == CW'(MD_CYCLES - 1));

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits shifting into quotient}.
    // A zero divisor always "fits", yielding all-ones quotient and rem = a.
    assign w_shift    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, opnd_q};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_next = {w_rem_next, acc_q[WIDTH-2:0], w_ge};

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        if (flush) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            is_div_d = (op == ALU_DIV);
            opnd_d   = (op == ALU_DIV) ? b : a;
            acc_d    = (op == ALU_DIV) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
        end else if (busy_q) begin
            acc_d = is_div_q ? w_div_next : w_mul_next;
            cnt_d = cnt_q + 1'b1;
            if (w_last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
        end
    end

    assign busy   = busy_q;
    assign done   = busy_q & w_last;
    assign result = acc_q;

endmodule

`default_nettype wire

// File: rtl/stage_two.sv
// ============================================================================
// stage_two : execute stage with EX/MEM register, stalls upstream during
//             iterative MUL/DIV. Define STAGE_TWO_FAST_MUL_EN for 1-cycle MUL.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stage_two
    import cpu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MD_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s2_valid,
    input  logic [3:0]         s2_aluop,
    input  logic [WIDTH-1:0]   s2_op1,
    input  logic [WIDTH-1:0]   s2_op2,
    input  logic [WIDTH-1:0]   s2_r1_data,
    input  logic [1:0]         s2_memc,
    input  logic [7:0]         s2_instruction,
    input  logic               s2_flush,
    output logic               s2_stall,
    output logic               s3_valid,
    output logic [2*WIDTH-1:0] s3_alu,
    output logic [1:0]         s3_memc,
    output logic [WIDTH-1:0]   s3_r1_data,
    output logic [7:0]         s3_instruction
);

    localparam int SHW = $clog2(WIDTH);

    md_state_t            state_q, state_d;
    logic                 s3_valid_q, s3_valid_d;
    logic [2*WIDTH-1:0]   s3_alu_q,   s3_alu_d;
    logic [1:0]           s3_memc_q,  s3_memc_d;
    logic [WIDTH-1:0]     s3_r1_q,    s3_r1_d;
    logic [7:0]           s3_instr_q, s3_instr_d;
    logic [1:0]           pend_memc_q,  pend_memc_d;
    logic [WIDTH-1:0]     pend_r1_q,    pend_r1_d;
    logic [7:0]           pend_instr_q, pend_instr_d;

    logic                 w_is_md;
    logic                 w_accept;
    logic [2*WIDTH-1:0]   w_alu;
    logic [SHW-1:0]       w_sh;
    logic signed [WIDTH-1:0] w_op1_s;
    logic [WIDTH-1:0]     w_sra;
    logic                 w_md_busy;
    logic                 w_md_done;
    logic [2*WIDTH-1:0]   w_md_result;

`ifdef STAGE_TWO_FAST_MUL_EN
    assign w_is_md = (s2_aluop == ALU_DIV);
`else
    assign w_is_md = (s2_aluop == ALU_DIV) || (s2_aluop == ALU_MUL);
`endif

    assign w_accept = (state_q == MD_IDLE) && s2_valid && w_is_md && !s2_flush;
    assign s2_stall = (state_q != MD_IDLE);

    assign w_sh    = s2_op2[SHW-1:0];
    assign w_op1_s = $signed(s2_op1);
    assign w_sra   = w_op1_s >>> w_sh;

    always_comb begin
        w_alu = '0;
        case (s2_aluop)
            ALU_ADD:   w_alu = {{WIDTH{1'b0}}, s2_op1 + s2_op2};
            ALU_SUB:   w_alu = {{WIDTH{1'b0}}, s2_op1 - s2_op2};
            ALU_AND:   w_alu = {{WIDTH{1'b0}}, s2_op1 & s2_op2};
            ALU_OR:    w_alu = {{WIDTH{1'b0}}, s2_op1 | s2_op2};
            ALU_XOR:   w_alu = {{WIDTH{1'b0}}, s2_op1 ^ s2_op2};
            ALU_NOT:   w_alu = {{WIDTH{1'b0}}, ~s2_op1};
            ALU_SLL:   w_alu = {{WIDTH{1'b0}}, s2_op1 << w_sh};
            ALU_SRL:   w_alu = {{WIDTH{1'b0}}, s2_op1 >> w_sh};
            ALU_SRA:   w_alu = {{WIDTH{1'b0}}, w_sra};
            ALU_PASSB: w_alu = {{WIDTH{1'b0}}, s2_op2};
`ifdef STAGE_TWO_FAST_MUL_EN
            ALU_MUL:   w_alu = {{WIDTH{1'b0}}, s2_op1} * {{WIDTH{1'b0}}, s2_op2};
`endif
            default:   w_alu = '0;
        endcase
    end

    md_unit #(
        .WIDTH     (WIDTH),
        .MD_CYCLES (MD_CYCLES)
    ) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (w_accept),
        .op     (alu_op_t'(s2_aluop)),
        .a      (s2_op1),
        .b      (s2_op2),
        .flush  (s2_flush),
        .busy   (w_md_busy),
        .done   (w_md_done),
        .result (w_md_result)
    );

    always_comb begin
        state_d = state_q;
        if (s2_flush) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: if (w_accept) state_d = MD_BUSY;
                MD_BUSY: begin
                    if (w_md_done)      state_d = MD_DONE;
                    else if (!w_md_busy) state_d = MD_IDLE;
                end
                MD_DONE: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    // s3_alu holds across bubbles; valid/memc are forced low so no stray store.
    always_comb begin
        s3_valid_d   = 1'b0;
        s3_memc_d    = 2'b00;
        s3_alu_d     = s3_alu_q;
        s3_r1_d      = s3_r1_q;
        s3_instr_d   = s3_instr_q;
        pend_memc_d  = pend_memc_q;
        pend_r1_d    = pend_r1_q;
        pend_instr_d = pend_instr_q;
        if (!s2_flush) begin
            case (state_q)
                MD_IDLE: begin
                    if (w_accept) begin
                        pend_memc_d[MEMC_MEMWR] = s2_memc[MEMC_MEMWR];
                        pend_memc_d[MEMC_MEM2R] = s2_memc[MEMC_MEM2R];
                        pend_r1_d    = s2_r1_data;
                        pend_instr_d = s2_instruction;
                    end else if (s2_valid) begin
                        s3_valid_d = 1'b1;
                        s3_alu_d   = w_alu;
                        s3_memc_d  = s2_memc;
                        s3_r1_d    = s2_r1_data;
                        s3_instr_d = s2_instruction;
                    end
                end
                MD_DONE: begin
                    s3_valid_d = 1'b1;
                    s3_alu_d   = w_md_result;
                    s3_memc_d  = pend_memc_q;
                    s3_r1_d    = pend_r1_q;
                    s3_instr_d = pend_instr_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= MD_IDLE;
            s3_valid_q   <= 1'b0;
            s3_alu_q     <= '0;
            s3_memc_q    <= 2'b00;
            s3_r1_q      <= '0;
            s3_instr_q   <= '0;
            pend_memc_q  <= 2'b00;
            pend_r1_q    <= '0;
            pend_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            s3_valid_q   <= s3_valid_d;
            s3_alu_q     <= s3_alu_d;
            s3_memc_q    <= s3_memc_d;
            s3_r1_q      <= s3_r1_d;
            s3_instr_q   <= s3_instr_d;
            pend_memc_q  <= pend_memc_d;
            pend_r1_q    <= pend_r1_d;
            pend_instr_q <= pend_instr_d;
        end
    end

    assign s3_valid       = s3_valid_q;
    assign s3_alu         = s3_alu_q;
    assign s3_memc        = s3_memc_q;
    assign s3_r1_data     = s3_r1_q;
    assign s3_instruction = s3_instr_q;

endmodule

`default_nettype wire
